// File: rtl/ram_loader_pkg.sv
// rtl/ram_loader_pkg.sv - shared state encoding and word geometry for ram_loader
//
// Purpose: FSM state encodings and helpers that derive the byte lane count of
//          a RAM word from its bit width.
// Contents: state_t, ST_IDLE/ST_COLLECT/ST_WRITE/ST_DONE,
//           bytes_per_word(), byte_cnt_width().
package ram_loader_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_COLLECT = 2'd1;
   localparam state_t ST_WRITE   = 2'd2;
   localparam state_t ST_DONE    = 2'd3;

   // Number of byte lanes in a RAM word of the given width.
   function automatic int bytes_per_word(input int data_width);
      return data_width / 8;
   endfunction

   // Width of a counter that indexes byte lanes; never narrower than 1 bit.
   function automatic int byte_cnt_width(input int nbytes);
      return (nbytes > 1) ? $clog2(nbytes) : 1;
   endfunction

endpackage

// File: rtl/ram_loader.sv
// rtl/ram_loader.sv - packs a byte stream into RAM words and writes them sequentially
//
// Purpose: On start, accepts word_count * BYTES bytes from a valid/ready byte
//          stream, assembles them little-endian into DATA_WIDTH words and writes
//          each word to consecutive addresses of a single-port RAM starting at
//          start_addr (address wraps). Keeps a modulo-256 checksum of accepted bytes.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start, start_addr,    one-cycle load request with first address and
//   word_count            number of words (sampled only when idle)
//   abort                 cancels an active load, no done pulse
//   in_data, in_valid,    byte stream input; byte consumed when
//   in_ready              in_valid && in_ready
//   ram_addr, ram_data_in,
//   ram_we                single-port RAM write port
//   busy, done, checksum  status
module ram_loader
   import ram_loader_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [ADDR_WIDTH:0]   word_count,
   input  logic                  abort,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_data_in,
   output logic                  ram_we,
   output logic                  busy,
   output logic                  done,
   output logic [7:0]            checksum
);

   localparam int BYTES = bytes_per_word(DATA_WIDTH);
   localparam int BCW   = byte_cnt_width(BYTES);

   localparam logic [BCW-1:0]      LAST_LANE = BCW'(BYTES - 1);
   localparam logic [ADDR_WIDTH:0] ONE_WORD  = (ADDR_WIDTH + 1)'(1);

   state_t                  state_q;
   state_t                  state_d;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [ADDR_WIDTH:0]     remaining_q;
   logic [BCW-1:0]          byte_cnt_q;
   logic [DATA_WIDTH-1:0]   word_q;
   logic [7:0]              checksum_q;

   logic                    accept;
   logic                    last_byte;
   logic                    start_ok;

   // abort outranks start when both arrive in IDLE
   assign start_ok  = start && !abort;
   assign accept    = in_valid && in_ready;
   assign last_byte = accept && (byte_cnt_q == LAST_LANE);

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start_ok) begin
               state_d = (word_count == '0) ? ST_DONE : ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (last_byte) begin
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else begin
               state_d = (remaining_q == ONE_WORD) ? ST_DONE : ST_COLLECT;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output logic. in_ready drops with abort so a byte offered during the
   // abort cycle stays with the source instead of being silently dropped.
   always_comb begin
      in_ready = 1'b0;
      ram_we   = 1'b0;
      busy     = 1'b1;
      done     = 1'b0;
      case (state_q)
         ST_IDLE:    busy     = 1'b0;
         ST_COLLECT: in_ready = !abort;
         ST_WRITE:   ram_we   = !abort;
         ST_DONE:    done     = 1'b1;
         default:    busy     = 1'b0;
      endcase
   end

   // Datapath: address/count capture, byte assembly, checksum
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q      <= '0;
         remaining_q <= '0;
         byte_cnt_q  <= '0;
         word_q      <= '0;
         checksum_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_ok) begin
                  addr_q      <= start_addr;
                  remaining_q <= word_count;
                  byte_cnt_q  <= '0;
                  word_q      <= '0;
                  checksum_q  <= '0;
               end
            end
            ST_COLLECT: begin
               if (abort) begin
                  byte_cnt_q <= '0;
               end else if (accept) begin
                  word_q[8*int'(byte_cnt_q) +: 8] <= in_data;
                  checksum_q <= checksum_q + in_data;
                  byte_cnt_q <= last_byte ? '0 : byte_cnt_q + BCW'(1);
               end
            end
            ST_WRITE: begin
               if (!abort) begin
                  // natural wrap of the address register gives modulo addressing
                  addr_q      <= addr_q + ADDR_WIDTH'(1);
                  remaining_q <= remaining_q - ONE_WORD;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign ram_addr    = addr_q;
   assign ram_data_in = word_q;
   assign checksum    = checksum_q;

endmodule
